// File: rtl/maquina_de_bebidas_param_if.sv
// maquina_de_bebidas_param_if: front-panel / actuator bundle for the vending controller.
//   Panel inputs : mc, md (5/10-unit coin pulses), ha (water), hs (per-drink ingredient),
//                  bsel (one-hot drink buttons), bcancel (refund request).
//   Status/actuators: dispensando, bebida_id, devolver, rechazo, falta, falla, credito, estado.
//   master = front panel / environment, slave = controller.
interface maquina_de_bebidas_param_if #(
    parameter int unsigned N_BEBIDAS = 2,
    parameter int unsigned CREDIT_W  = 6
);
    localparam int unsigned ID_W = (N_BEBIDAS > 1) ? $clog2(N_BEBIDAS) : 1;

    logic                 mc;
    logic                 md;
    logic                 ha;
    logic [N_BEBIDAS-1:0] hs;
    logic [N_BEBIDAS-1:0] bsel;
    logic                 bcancel;
    logic                 dispensando;
    logic [ID_W-1:0]      bebida_id;
    logic                 devolver;
    logic                 rechazo;
    logic                 falta;
    logic                 falla;
    logic [CREDIT_W-1:0]  credito;
    logic [1:0]           estado;

    modport master (
        output mc, md, ha, hs, bsel, bcancel,
        input  dispensando, bebida_id, devolver, rechazo, falta, falla, credito, estado
    );

    modport slave (
        input  mc, md, ha, hs, bsel, bcancel,
        output dispensando, bebida_id, devolver, rechazo, falta, falla, credito, estado
    );
endinterface

// File: rtl/maquina_de_bebidas_param.sv
// maquina_de_bebidas_param: parametrised beverage-vending controller.
//   clk  : single clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : slave side of maquina_de_bebidas_param_if (coins, sensors, buttons in;
//          dispenser, coin return, status pulses, credit and state out).
// Credit is kept in 5-unit units. All outputs are registered.
module maquina_de_bebidas_param #(
    parameter int unsigned N_BEBIDAS      = 2,
    parameter int unsigned CREDIT_W       = 6,
    parameter int unsigned PRECIO         = 2,
    parameter int unsigned PREP_CYCLES    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic                       clk,
    input logic                       rst,
    maquina_de_bebidas_param_if.slave bus
);
    localparam int unsigned ID_W = (N_BEBIDAS > 1) ? $clog2(N_BEBIDAS) : 1;
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned PR_W = (PREP_CYCLES > 1) ? $clog2(PREP_CYCLES) : 1;
    // Two guard bits so credit + 3 never wraps before the saturation compare.
    localparam int unsigned CX_W = CREDIT_W + 2;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] CREDITO  = 2'd1;
    localparam logic [1:0] PREPARAR = 2'd2;
    localparam logic [1:0] CAMBIO   = 2'd3;

    localparam logic [CX_W-1:0] CREDIT_MAX = {2'b00, {CREDIT_W{1'b1}}};
    localparam logic [CX_W-1:0] PRICE      = CX_W'(PRECIO);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PR_W-1:0] PR_LAST    = PR_W'(PREP_CYCLES - 1);

    logic [1:0]          estado_q, estado_d;
    logic [CREDIT_W-1:0] credito_q, credito_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic [PR_W-1:0]     prep_q, prep_d;
    logic                disp_q, dev_q;
    logic                rech_q, rech_d;
    logic                falta_q, falta_d;
    logic                falla_q, falla_d;

    logic                coin, coin_fits, sel_valid, drink_ok, activity;
    logic [CX_W-1:0]     coin_v, credit_x, credit_new;
    logic [ID_W-1:0]     sel_idx;

    assign coin      = bus.mc | bus.md;
    assign coin_v    = CX_W'({bus.md, bus.mc});
    assign credit_x  = {2'b00, credito_q};
    assign coin_fits = (credit_x + coin_v) <= CREDIT_MAX;
    assign sel_valid = $onehot(bus.bsel);
    assign drink_ok  = bus.ha && (|(bus.hs & bus.bsel));
    assign activity  = (coin && coin_fits) || bus.bcancel || (|bus.bsel);
    assign credito_d = credit_new[CREDIT_W-1:0];

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < N_BEBIDAS; i++) begin
            if (bus.bsel[i]) sel_idx = ID_W'(i);
        end
    end

    always_comb begin
        estado_d   = estado_q;
        credit_new = credit_x;
        id_d       = id_q;
        to_d       = '0;
        prep_d     = '0;
        rech_d     = 1'b0;
        falta_d    = 1'b0;
        falla_d    = 1'b0;
        unique case (estado_q)
            IDLE: begin
                if (coin) begin
                    if (coin_fits) begin
                        credit_new = credit_x + coin_v;
                        estado_d   = CREDITO;
                    end else begin
                        rech_d = 1'b1;
                    end
                end
            end
            CREDITO: begin
                // Button decision uses the registered credit; a same-cycle coin lands on top.
                if (bus.bcancel) begin
                    estado_d = CAMBIO;
                end else if (sel_valid) begin
                    if (credit_x < PRICE) begin
                        falta_d = 1'b1;
                    end else if (!drink_ok) begin
                        falla_d  = 1'b1;
                        estado_d = CAMBIO;
                    end else begin
                        credit_new = credit_x - PRICE;
                        id_d       = sel_idx;
                        estado_d   = PREPARAR;
                    end
                end
                if (coin) begin
                    if (coin_fits) credit_new = credit_new + coin_v;
                    else           rech_d     = 1'b1;
                end
                if (activity) begin
                    to_d = '0;
                end else if (to_q == TO_LAST) begin
                    estado_d = CAMBIO;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            PREPARAR: begin
                rech_d = coin;
                if (prep_q == PR_LAST) estado_d = CAMBIO;
                else                   prep_d   = prep_q + 1'b1;
            end
            CAMBIO: begin
                rech_d = coin;
                if (credit_x != '0) credit_new = credit_x - 1'b1;
            end
        endcase
        // CAMBIO only while there is something left to return.
        if (estado_d == CAMBIO && credit_new == '0) estado_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q  <= IDLE;
            credito_q <= '0;
            id_q      <= '0;
            to_q      <= '0;
            prep_q    <= '0;
            disp_q    <= 1'b0;
            dev_q     <= 1'b0;
            rech_q    <= 1'b0;
            falta_q   <= 1'b0;
            falla_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            credito_q <= credito_d;
            id_q      <= id_d;
            to_q      <= to_d;
            prep_q    <= prep_d;
            disp_q    <= (estado_d == PREPARAR);
            dev_q     <= (estado_d == CAMBIO);
            rech_q    <= rech_d;
            falta_q   <= falta_d;
            falla_q   <= falla_d;
        end
    end

    assign bus.estado      = estado_q;
    assign bus.credito     = credito_q;
    assign bus.bebida_id   = id_q;
    assign bus.dispensando = disp_q;
    assign bus.devolver    = dev_q;
    assign bus.rechazo     = rech_q;
    assign bus.falta       = falta_q;
    assign bus.falla       = falla_q;
endmodule

// File: tb/tb_maquina_de_bebidas_param.sv
// tb_maquina_de_bebidas_param: directed test-plan scenarios followed by randomized panel
// activity, all checked cycle by cycle against a behavioural model of the vending rules.
module tb_maquina_de_bebidas_param;
    localparam int N       = 2;
    localparam int CW      = 6;
    localparam int PRECIO  = 2;
    localparam int PREP    = 8;
    localparam int TIMEOUT = 64;
    localparam int MAXC    = (1 << CW) - 1;

    localparam int S_IDLE = 0, S_CRED = 1, S_PREP = 2, S_CAMBIO = 3;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    // Reference model state
    int m_state, m_credit, m_idle, m_prep, m_id;
    bit m_rech, m_falta, m_falla;

    maquina_de_bebidas_param_if #(.N_BEBIDAS(N), .CREDIT_W(CW)) bus ();

    maquina_de_bebidas_param #(
        .N_BEBIDAS     (N),
        .CREDIT_W      (CW),
        .PRECIO        (PRECIO),
        .PREP_CYCLES   (PREP),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_credit = 0; m_idle = 0; m_prep = 0; m_id = 0;
        m_rech = 0; m_falta = 0; m_falla = 0;
    endtask

    // One clock edge of the vending rules, applied to the inputs currently on the panel.
    task automatic model_step();
        int v, pre, newc, nxt, sel;
        bit accepted, activity;
        v = int'(bus.mc) + 2 * int'(bus.md);
        m_rech = 0; m_falta = 0; m_falla = 0;
        case (m_state)
            S_IDLE: begin
                if (v > 0) begin
                    if (m_credit + v > MAXC) m_rech = 1;
                    else begin m_credit += v; m_state = S_CRED; m_idle = 0; end
                end
            end
            S_CRED: begin
                pre = m_credit; newc = pre; nxt = S_CRED;
                accepted = (v > 0) && (pre + v <= MAXC);
                if (v > 0 && !accepted) m_rech = 1;
                activity = accepted || bus.bcancel || (bus.bsel != 0);
                if (bus.bcancel) nxt = S_CAMBIO;
                else if ($countones(bus.bsel) == 1) begin
                    sel = 0;
                    for (int i = 0; i < N; i++) if (bus.bsel[i]) sel = i;
                    if (pre < PRECIO) m_falta = 1;
                    else if (!bus.ha || !bus.hs[sel]) begin m_falla = 1; nxt = S_CAMBIO; end
                    else begin newc = pre - PRECIO; m_id = sel; m_prep = PREP; nxt = S_PREP; end
                end
                if (accepted) newc += v;
                if (activity) m_idle = 0;
                else begin
                    m_idle++;
                    if (m_idle >= TIMEOUT) nxt = S_CAMBIO;
                end
                m_credit = newc;
                m_state  = (nxt == S_CAMBIO && newc == 0) ? S_IDLE : nxt;
            end
            S_PREP: begin
                m_rech = (v > 0);
                m_prep--;
                if (m_prep == 0) m_state = (m_credit > 0) ? S_CAMBIO : S_IDLE;
            end
            default: begin
                m_rech = (v > 0);
                m_credit--;
                if (m_credit == 0) m_state = S_IDLE;
            end
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".estado"},      32'(bus.estado),      32'(m_state));
        chk({tag, ".credito"},     32'(bus.credito),     32'(m_credit));
        chk({tag, ".bebida_id"},   32'(bus.bebida_id),   32'(m_id));
        chk({tag, ".dispensando"}, 32'(bus.dispensando), 32'(m_state == S_PREP));
        chk({tag, ".devolver"},    32'(bus.devolver),    32'(m_state == S_CAMBIO));
        chk({tag, ".rechazo"},     32'(bus.rechazo),     32'(m_rech));
        chk({tag, ".falta"},       32'(bus.falta),       32'(m_falta));
        chk({tag, ".falla"},       32'(bus.falla),       32'(m_falla));
    endtask

    task automatic idle_in();
        bus.mc = 1'b0; bus.md = 1'b0; bus.ha = 1'b1;
        bus.hs = '1; bus.bsel = '0; bus.bcancel = 1'b0;
    endtask

    // Advance one edge: model consumes the current inputs, DUT sampled 1 time unit later.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all("model");
    endtask

    initial begin
        int  disp_cnt, dev_cnt;
        bit  quiet;
        int  r;
        tests_run = 0; tests_failed = 0;
        rst = 1'b0;
        idle_in();
        model_reset();
        #2;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Exact credit: 10-unit coin buys drink 0, no change.
        bus.md = 1'b1; cycle(); idle_in();
        chk("exact.credito", 32'(bus.credito), 2);
        bus.bsel = N'(1); cycle(); idle_in();
        chk("exact.bebida_id", 32'(bus.bebida_id), 0);
        chk("exact.credito0", 32'(bus.credito), 0);
        disp_cnt = int'(bus.dispensando); dev_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            disp_cnt += int'(bus.dispensando); dev_cnt += int'(bus.devolver);
        end
        chk("exact.disp_cycles", 32'(disp_cnt), 8);
        chk("exact.devolver", 32'(dev_cnt), 0);
        chk("exact.idle", 32'(bus.estado), S_IDLE);

        // Change: both coins at once, drink 1, one coin back.
        bus.md = 1'b1; bus.mc = 1'b1; cycle(); idle_in();
        chk("change.credito3", 32'(bus.credito), 3);
        bus.bsel = N'(2); cycle(); idle_in();
        chk("change.bebida_id", 32'(bus.bebida_id), 1);
        chk("change.credito1", 32'(bus.credito), 1);
        disp_cnt = int'(bus.dispensando); dev_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            disp_cnt += int'(bus.dispensando); dev_cnt += int'(bus.devolver);
        end
        chk("change.disp_cycles", 32'(disp_cnt), 8);
        chk("change.devolver", 32'(dev_cnt), 1);
        chk("change.idle", 32'(bus.estado), S_IDLE);

        // Insufficient credit, then inactivity timeout.
        bus.mc = 1'b1; cycle(); idle_in();
        bus.bsel = N'(1); cycle(); idle_in();
        chk("falta.pulse", 32'(bus.falta), 1);
        chk("falta.credito", 32'(bus.credito), 1);
        cycle();
        chk("falta.single", 32'(bus.falta), 0);
        repeat (62) cycle();
        chk("timeout.before", 32'(bus.estado), S_CRED);
        cycle();
        chk("timeout.cambio", 32'(bus.estado), S_CAMBIO);
        chk("timeout.devolver", 32'(bus.devolver), 1);
        cycle();
        chk("timeout.idle", 32'(bus.estado), S_IDLE);

        // Missing water: full refund of 4.
        bus.md = 1'b1; cycle(); cycle(); idle_in();
        chk("falla.credito4", 32'(bus.credito), 4);
        bus.ha = 1'b0; bus.bsel = N'(1); cycle(); idle_in();
        chk("falla.pulse", 32'(bus.falla), 1);
        chk("falla.credito", 32'(bus.credito), 4);
        disp_cnt = int'(bus.dispensando); dev_cnt = int'(bus.devolver);
        for (int i = 0; i < 8; i++) begin
            cycle();
            disp_cnt += int'(bus.dispensando); dev_cnt += int'(bus.devolver);
        end
        chk("falla.devolver", 32'(dev_cnt), 4);
        chk("falla.nodisp", 32'(disp_cnt), 0);
        chk("falla.credito0", 32'(bus.credito), 0);

        // Saturation at full scale, then a coin while busy.
        bus.md = 1'b1; repeat (31) cycle(); idle_in();
        bus.mc = 1'b1; cycle(); idle_in();
        chk("sat.full", 32'(bus.credito), MAXC);
        bus.md = 1'b1; cycle(); idle_in();
        chk("sat.rechazo", 32'(bus.rechazo), 1);
        chk("sat.credito", 32'(bus.credito), MAXC);
        bus.bsel = N'(1); cycle(); idle_in();
        bus.mc = 1'b1; cycle(); idle_in();
        chk("busy.rechazo", 32'(bus.rechazo), 1);
        chk("busy.credito", 32'(bus.credito), MAXC - PRECIO);
        for (int i = 0; i < 100 && bus.estado != 2'd0; i++) cycle();
        chk("sat.drained", 32'(bus.estado), S_IDLE);

        // Asynchronous reset in the 4th PREPARAR cycle.
        bus.md = 1'b1; cycle(); idle_in();
        bus.bsel = N'(1); cycle(); idle_in();
        repeat (3) cycle();
        chk("rst.pre_disp", 32'(bus.dispensando), 1);
        #3; rst = 1'b0; #1;
        chk("rst.disp", 32'(bus.dispensando), 0);
        chk("rst.credito", 32'(bus.credito), 0);
        chk("rst.estado", 32'(bus.estado), S_IDLE);
        model_reset();
        @(posedge clk); #1;
        check_all("rst_hold");
        @(negedge clk);
        rst = 1'b1;
        bus.mc = 1'b1; cycle(); idle_in();
        chk("rst.resume_credito", 32'(bus.credito), 1);
        bus.bcancel = 1'b1; cycle(); idle_in();
        chk("rst.cancel", 32'(bus.estado), S_CAMBIO);
        cycle();
        chk("rst.back_idle", 32'(bus.estado), S_IDLE);

        // Randomized panel activity; quiet windows let the timeout fire.
        quiet = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 128 == 0) quiet = ($urandom_range(0, 2) == 0);
            bus.mc = quiet ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 3) == 0);
            bus.md = quiet ? 1'b0 : ($urandom_range(0, 4) == 0);
            bus.ha = ($urandom_range(0, 9) != 0);
            bus.hs = ($urandom_range(0, 5) == 0) ? N'($urandom) : '1;
            r = quiet ? int'($urandom_range(0, 299)) + 3 : int'($urandom_range(0, 9));
            if (r == 0)      bus.bsel = N'(1 << $urandom_range(0, N - 1));
            else if (r == 1) bus.bsel = N'($urandom);
            else if (r == 3) bus.bsel = N'(1);
            else             bus.bsel = '0;
            bus.bcancel = quiet ? 1'b0 : ($urandom_range(0, 39) == 0);
            cycle();
        end
        idle_in();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
